// File: rtl/light_package.sv
// Shared light-controller types: lamp colours and the scheduler phase.
package light_package;

    typedef enum logic [1:0] {
        red    = 2'd0,
        yellow = 2'd1,
        green  = 2'd2
    } colors;

    typedef enum logic [1:0] {
        ALLRED = 2'd0,
        GREEN  = 2'd1,
        YELLOW = 2'd2
    } phase_t;

endpackage

// File: rtl/tlc_dwell_timer.sv
// Saturating dwell counter: clears on request, otherwise counts up to SAT and holds.
module tlc_dwell_timer #(
    parameter int W   = 3,
    parameter int SAT = 7
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    output logic [W-1:0] tmr
);

    localparam logic [W-1:0] SAT_V = W'(SAT);

    // Count cycles since the last clear, holding at the saturation value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmr <= '0;
        end else if (clr) begin
            tmr <= '0;
        end else if (tmr != SAT_V) begin
            tmr <= tmr + 1'b1;
        end
    end

endmodule

// File: rtl/tlc_3way_sched.sv
// Three-approach traffic-light scheduler: round-robin grants with min/max green,
// fixed yellow and an all-red clearance between every change of right-of-way.
module tlc_3way_sched
    import light_package::*;
#(
    parameter int MIN_GREEN = 3,
    parameter int MAX_GREEN = 8,
    parameter int YELLOW_T  = 2,
    parameter int ALLRED_T  = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       Ta,
    input  logic       Tb,
    input  logic       Tc,
    output colors      La,
    output colors      Lb,
    output colors      Lc,
    output logic [1:0] owner
);

    localparam int TW = (MAX_GREEN > 1) ? $clog2(MAX_GREEN) : 1;

    phase_t          phase;
    logic [TW-1:0]   tmr;
    logic [2:0]      req;
    logic [2:0]      owner_mask;
    logic            others;
    logic            own_req;
    logic            advance;
    logic [1:0]      grant;
    int              tmr_i;

    // Next street in rotation after cur; ties are broken only by this order.
    function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] cur);
        logic [1:0] c1;
        logic [1:0] c2;
        c1 = (cur == 2'd2) ? 2'd0 : cur + 2'd1;
        c2 = (c1 == 2'd2) ? 2'd0 : c1 + 2'd1;
        if (r[c1]) begin
            return c1;
        end else if (r[c2]) begin
            return c2;
        end
        return cur;
    endfunction

    // Lamp value for street s when street sel shows colour col.
    function automatic colors paint(input logic [1:0] s, input logic [1:0] sel, input colors col);
        return (s == sel) ? col : red;
    endfunction

    assign req        = {Tc, Tb, Ta};
    assign owner_mask = 3'b001 << owner;
    assign others     = |(req & ~owner_mask);
    assign own_req    = |(req & owner_mask);
    assign tmr_i      = int'(tmr);

    // Phase-exit decision; the same condition restarts the dwell timer on entry.
    always_comb begin
        advance = 1'b0;
        grant   = rr_pick(req, owner);
        case (phase)
            ALLRED:  advance = (tmr_i >= ALLRED_T - 1) && (|req);
            GREEN:   advance = (tmr_i >= MIN_GREEN - 1) && others &&
                               (!own_req || (tmr_i == MAX_GREEN - 1));
            YELLOW:  advance = (tmr_i == YELLOW_T - 1);
            default: advance = 1'b0;
        endcase
    end

    tlc_dwell_timer #(
        .W   (TW),
        .SAT (MAX_GREEN - 1)
    ) u_dwell (
        .clk   (clk),
        .reset (reset),
        .clr   (advance),
        .tmr   (tmr)
    );

    // Phase/owner state with lamps registered alongside so they decode the new state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase <= ALLRED;
            owner <= 2'd2;
            La    <= red;
            Lb    <= red;
            Lc    <= red;
        end else if (advance) begin
            case (phase)
                ALLRED: begin
                    phase <= GREEN;
                    owner <= grant;
                    La    <= paint(2'd0, grant, green);
                    Lb    <= paint(2'd1, grant, green);
                    Lc    <= paint(2'd2, grant, green);
                end
                GREEN: begin
                    phase <= YELLOW;
                    La    <= paint(2'd0, owner, yellow);
                    Lb    <= paint(2'd1, owner, yellow);
                    Lc    <= paint(2'd2, owner, yellow);
                end
                default: begin
                    phase <= ALLRED;
                    La    <= red;
                    Lb    <= red;
                    Lc    <= red;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tlc_3way_sched.sv
// Bench for tlc_3way_sched: directed scenarios plus randomized sensors,
// all checked against a cycle-count reference model of the scheduling rules.
module tb_tlc_3way_sched;
    import light_package::*;

    localparam int MIN_G = 3;
    localparam int MAX_G = 8;
    localparam int YEL_T = 2;
    localparam int AR_T  = 1;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic       Ta    = 1'b0;
    logic       Tb    = 1'b0;
    logic       Tc    = 1'b0;
    colors      La;
    colors      Lb;
    colors      Lc;
    logic [1:0] owner;

    int vectors = 0;
    int errors  = 0;

    // Reference model: m_ph 0=all red, 1=green, 2=yellow; m_age = cycles since entry.
    int m_ph;
    int m_own;
    int m_age;

    tlc_3way_sched #(
        .MIN_GREEN (MIN_G),
        .MAX_GREEN (MAX_G),
        .YELLOW_T  (YEL_T),
        .ALLRED_T  (AR_T)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .Ta    (Ta),
        .Tb    (Tb),
        .Tc    (Tc),
        .La    (La),
        .Lb    (Lb),
        .Lc    (Lc),
        .owner (owner)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_ph  = 0;
        m_own = 2;
        m_age = 0;
    endtask

    function automatic colors exp_light(input int s);
        if (m_ph == 1 && s == m_own) return green;
        if (m_ph == 2 && s == m_own) return yellow;
        return red;
    endfunction

    // One rising edge: advance the model from the sensors in effect, then settle.
    task automatic tick();
        bit r[3];
        int pick;
        bit oth;
        @(posedge clk);
        r = '{Ta, Tb, Tc};
        if (!reset) begin
            model_reset();
        end else if (m_ph == 0) begin
            pick = -1;
            for (int k = 1; k <= 3; k++)
                if (pick < 0 && r[(m_own + k) % 3]) pick = (m_own + k) % 3;
            if (m_age >= AR_T - 1 && pick >= 0) begin
                m_ph = 1; m_own = pick; m_age = 0;
            end else m_age++;
        end else if (m_ph == 1) begin
            oth = 0;
            for (int s = 0; s < 3; s++) if (s != m_own && r[s]) oth = 1;
            if (m_age >= MIN_G - 1 && oth && (!r[m_own] || m_age >= MAX_G - 1)) begin
                m_ph = 2; m_age = 0;
            end else m_age++;
        end else begin
            if (m_age == YEL_T - 1) begin
                m_ph = 0; m_age = 0;
            end else m_age++;
        end
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        Ta = 1; Tb = 1; Tc = 1;
        reset = 1'b0;
        #1;
        model_reset();
        for (int i = 0; i < 5; i++) begin
            tick();
            vectors++;
            if ({La, Lb, Lc, owner} !== {red, red, red, 2'd2}) begin
                errors++;
                $display("FAIL reset_hold: La=%s Lb=%s Lc=%s owner=%0d, need all red owner=2",
                         La.name(), Lb.name(), Lc.name(), owner);
            end
        end
    endtask

    task automatic test_uncontended();
        Ta = 1; Tb = 0; Tc = 0;
        apply_reset();
        for (int i = 0; i < 50; i++) begin
            tick();
            vectors++;
            if ({La, Lb, Lc, owner} !== {green, red, red, 2'd0}) begin
                errors++;
                $display("FAIL rest_on_green cyc%0d: La=%s Lb=%s Lc=%s owner=%0d, need A green",
                         i, La.name(), Lb.name(), Lc.name(), owner);
            end
        end
    endtask

    // Ta held (or dropped) when Tb rises on A's first green cycle; measure A's sequence.
    task automatic test_handover(input string name, input bit hold_a, input int exp_g);
        int a_g, a_y, ar, n;
        Ta = 1; Tb = 0; Tc = 0;
        apply_reset();
        tick();
        a_g = (La == green) ? 1 : 0;
        a_y = 0; ar = 0; n = 0;
        Tb = 1;
        Ta = hold_a;
        while (n < 40) begin
            tick();
            n++;
            vectors++;
            if ({La, Lb, Lc, owner} !== {exp_light(0), exp_light(1), exp_light(2), 2'(m_own)}) begin
                errors++;
                $display("FAIL %s_model cyc%0d: La=%s Lb=%s Lc=%s owner=%0d, need %s %s %s %0d",
                         name, n, La.name(), Lb.name(), Lc.name(), owner,
                         exp_light(0).name(), exp_light(1).name(), exp_light(2).name(), m_own);
            end
            if (Lb == green) break;
            if (La == green) a_g++;
            else if (La == yellow) a_y++;
            else ar++;
        end
        vectors++;
        if (n >= 40 || a_g != exp_g || a_y != YEL_T || ar != AR_T || owner !== 2'd1) begin
            errors++;
            $display("FAIL %s_seq: green=%0d yellow=%0d allred=%0d owner=%0d, need %0d/%0d/%0d owner=1",
                     name, a_g, a_y, ar, owner, exp_g, YEL_T, AR_T);
        end
    endtask

    task automatic test_rotation();
        int exp_order[4] = '{0, 1, 2, 0};
        int g, prev_g, run_len, gap, runs, nonred;
        Ta = 1; Tb = 1; Tc = 1;
        apply_reset();
        prev_g = -1; run_len = 0; gap = 0; runs = 0;
        for (int n = 0; n < 200 && runs < 4; n++) begin
            tick();
            nonred = (La != red) + (Lb != red) + (Lc != red);
            vectors++;
            if (nonred > 1 || nonred != ((m_ph == 0) ? 0 : 1)) begin
                errors++;
                $display("FAIL rot_exclusive cyc%0d: %0d lights non-red, need %0d", n, nonred,
                         (m_ph == 0) ? 0 : 1);
            end
            g = (La == green) ? 0 : (Lb == green) ? 1 : (Lc == green) ? 2 : -1;
            if (g >= 0) begin
                if (prev_g < 0) begin
                    vectors++;
                    if (g != exp_order[runs] || (runs > 0 && gap != YEL_T + AR_T)) begin
                        errors++;
                        $display("FAIL rot_grant%0d: street=%0d gap=%0d, need street=%0d gap=%0d",
                                 runs, g, gap, exp_order[runs], YEL_T + AR_T);
                    end
                    run_len = 1;
                end else run_len++;
            end else begin
                if (prev_g >= 0) begin
                    vectors++;
                    if (run_len != MAX_G) begin
                        errors++;
                        $display("FAIL rot_dwell%0d: green %0d cycles, need %0d", runs, run_len, MAX_G);
                    end
                    runs++;
                    gap = 0;
                end
                gap++;
            end
            prev_g = g;
        end
        vectors++;
        if (runs < 4) begin
            errors++;
            $display("FAIL rot_timeout: %0d greens completed, need 4", runs);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        bit got_green;
        Ta = 1; Tb = 1; Tc = 1;
        apply_reset();
        n = 0;
        while (Lb != yellow && n < 60) begin
            tick();
            n++;
        end
        vectors++;
        if (Lb != yellow) begin
            errors++;
            $display("FAIL midrst_reach: Lb=%s, need yellow within 60 cycles", Lb.name());
        end
        reset = 1'b0;
        #1;
        model_reset();
        vectors++;
        if ({La, Lb, Lc, owner} !== {red, red, red, 2'd2}) begin
            errors++;
            $display("FAIL midrst_async: La=%s Lb=%s Lc=%s owner=%0d, need all red owner=2",
                     La.name(), Lb.name(), Lc.name(), owner);
        end
        tick();
        reset = 1'b1;
        got_green = 0;
        for (int i = 0; i < 10 && !got_green; i++) begin
            tick();
            if (La == green || Lb == green || Lc == green) begin
                got_green = 1;
                vectors++;
                if (La != green) begin
                    errors++;
                    $display("FAIL midrst_first: La=%s Lb=%s Lc=%s, need A green first",
                             La.name(), Lb.name(), Lc.name());
                end
            end
        end
        vectors++;
        if (!got_green) begin
            errors++;
            $display("FAIL midrst_timeout: no green within 10 cycles after release");
        end
    endtask

    task automatic test_random();
        Ta = 0; Tb = 0; Tc = 0;
        apply_reset();
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 7) == 0) Ta = ~Ta;
            if ($urandom_range(0, 7) == 0) Tb = ~Tb;
            if ($urandom_range(0, 7) == 0) Tc = ~Tc;
            tick();
            vectors++;
            if ({La, Lb, Lc, owner} !== {exp_light(0), exp_light(1), exp_light(2), 2'(m_own)}) begin
                errors++;
                $display("FAIL random cyc%0d: La=%s Lb=%s Lc=%s owner=%0d, need %s %s %s %0d",
                         n, La.name(), Lb.name(), Lc.name(), owner,
                         exp_light(0).name(), exp_light(1).name(), exp_light(2).name(), m_own);
            end
        end
    endtask

    initial begin
        test_reset();
        test_uncontended();
        test_handover("max_green", 1'b1, MAX_G);
        test_handover("min_green", 1'b0, MIN_G);
        test_rotation();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/tlc_3way_sched.md
# tlc_3way_sched

Three-street traffic-light scheduler for the intersection controller family. It shares the single intersection between three approaches (A, B, C) using round-robin arbitration of the vehicle sensors. It enforces minimum and maximum green, a fixed yellow and an all-red clearance interval between every change of right-of-way. It drives the `colors` light outputs directly and is the successor to the two-street 6-state controller.

## Interface
- `MIN_GREEN`, default 3: minimum green dwell, in cycles (≥1).
- `MAX_GREEN`, default 8: green dwell after which a contended green is forced to yield (≥`MIN_GREEN`).
- `YELLOW_T`, default 2: yellow duration, in cycles (≥1).
- `ALLRED_T`, default 1: minimum all-red clearance, in cycles (≥1).
- `clk` input, 1 bit: single clock; all state changes on the rising edge.
- `reset` input, 1 bit: asynchronous, active-low (0 = reset asserted); released synchronously by bench/system.
- `Ta`, `Tb`, `Tc` inputs, 1 bit each: traffic present on street A/B/C (level, sampled at `clk` edge).
- `La`, `Lb`, `Lc` outputs, `colors`: light for street A/B/C.
- `owner` output, 2 bits: street holding or last holding right-of-way (0=A, 1=B, 2=C).

## Operation
- State register: `phase` ∈ {ALLRED, GREEN, YELLOW}, plus `owner`, plus dwell timer `tmr`.
- Outputs are pure decode of registers:
  - In GREEN, street `owner` = green, others red.
  - In YELLOW, `owner` = yellow, others red.
  - In ALLRED, all red.
- Reset values: `phase`=ALLRED, `owner`=2 (so A is searched first), `tmr`=0, La=Lb=Lc=red.
- `tmr` clears on every phase entry and increments each cycle. It saturates at `MAX_GREEN-1`; it never wraps.
- `req` = {Tc, Tb, Ta}. `others` = any request from a street ≠ `owner`.
- **ALLRED**
  - Leave when `tmr ≥ ALLRED_T-1` and any `req` bit is set.
  - New owner = first requesting street in order owner+1, owner+2, owner (mod 3).
  - Enter GREEN.
  - With no request, stay in ALLRED indefinitely (all red, `tmr` saturates).
- **GREEN**
  - Go to YELLOW when `tmr ≥ MIN_GREEN-1` and `others`, and either (a) the owner's sensor is low, or (b) `tmr == MAX_GREEN-1`.
  - Without `others`, green holds indefinitely, regardless of the owner's sensor (rest-on-green).
- **YELLOW**
  - Lasts exactly `YELLOW_T` cycles, then ALLRED.
  - `owner` is unchanged until the next grant.
- Round-robin guarantees no street waits longer than 2 full green+yellow+allred cycles while its sensor is held.
- Simultaneous requests are resolved only by the rotation order. Sensor changes during YELLOW/ALLRED have no effect until the ALLRED decision edge.
- Reset asserted mid-operation forces the reset values immediately (asynchronously); there is no yellow on abort.

## Timing
- Decision latency:
  - A request seen at an ALLRED-exit edge shows green on that same edge (outputs registered-state decode, zero extra cycles).
  - From reset release with Ta=1: green at the `ALLRED_T`-th rising edge.
- Green dwell ∈ [`MIN_GREEN`, `MAX_GREEN`] cycles when contended; unbounded when uncontended.
- Handover A→B minimum = `MIN_GREEN` + `YELLOW_T` + `ALLRED_T` cycles of A's right-of-way sequence before B green. With defaults, 3+2+1.
- `tmr` width = `$clog2(MAX_GREEN)` bits, minimum 1.

## Structure
- `light_package` already holds `colors` (red, yellow, green). Add the `phase_t` enum {ALLRED, GREEN, YELLOW} there.
- Round-robin pick is an internal function in the main module.
- One sub-module: `tlc_dwell_timer`, a saturating up-counter with `clr` and parameterized saturation value, reset to 0.

## Test plan
Clock period 10 ns; default parameters throughout.
- Reset held low with Ta=Tb=Tc=1 → La=Lb=Lc=red, `owner`=2 throughout.
- Release reset, Ta=1 only → La=green after 1 edge; holds green for 50 cycles; Lb=Lc=red.
- Ta held, Tb raised at A's green cycle 1 → A green 8 cycles total, yellow 2, all-red 1, then Lb=green, `owner`=1.
- Tb raised at A's green cycle 1, Ta dropped at the same time → A still green 3 cycles, then yellow 2, all-red 1, then B green.
- Ta=Tb=Tc=1 continuously → greens rotate A, B, C, A, each 8 cycles with 3-cycle gaps. Assert that exactly one light is non-red at any cycle.
- Reset pulsed low during B yellow → all red in the same cycle, `owner`=2. After release with all sensors high → A gets green first.
